// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder
// Converts each rising edge on the resynchronised multiphase hit samples into
// a {coarse, fine} timestamp. Coarse comes from a free-running cycle counter.
// Fine comes from a popcount of the phase samples, so bubbles in the
// thermometer code do no harm. Timestamps are queued in a FIFO with a
// registered head for the readout side. A dead-time / wait-low FSM makes sure
// that each pulse on the hit line produces only one entry.
module tdc_hit_encoder #(
    parameter int  NPHASE     = 12,
    parameter int  COARSE_W   = 24,
    parameter int  FIFO_DEPTH = 16,
    parameter int  DEAD_CYC   = 4,
    localparam int FINE_W     = $clog2(NPHASE),
    localparam int TS_W       = COARSE_W + FINE_W,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NPHASE-1:0] phase_smp,
    output logic [TS_W-1:0]   ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [15:0]       overflow_cnt,
    output logic              armed
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(NPHASE + 1);
    localparam int DCNT_W = $clog2(DEAD_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DEAD,
        WAIT_LOW
    } state_t;

    // coarse counter and stage-1 sample registers
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [NPHASE-1:0]   smp_q, smp_d;
    logic [COARSE_W-1:0] crs_q, crs_d;

    // capture FSM
    state_t              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

    // stage-2 timestamp register
    logic [TS_W-1:0]     s2_ts_q, s2_ts_d;
    logic                wr_req_q, wr_req_d;

    // FIFO storage, pointers and registered head
    logic [TS_W-1:0]     mem_q [FIFO_DEPTH];
    logic [TS_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [TS_W-1:0]     ts_data_q, ts_data_d;
    logic                ts_valid_q, ts_valid_d;
    logic [15:0]         ovf_q, ovf_d;

    // combinational helpers
    logic [CNT_W-1:0]    pop_cnt;
    logic [CNT_W-1:0]    fine_full;
    logic [FINE_W-1:0]   fine;
    logic                hit;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // Coarse counting and stage-1 capture of the samples with their cycle number
    always_comb begin
        coarse_d = coarse_q;
        if (en) begin
            coarse_d = coarse_q + COARSE_W'(1);
        end
        smp_d = phase_smp;
        crs_d = coarse_q;
    end

    // Fine code: more phases already high means an earlier arrival, so a smaller fine value
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NPHASE; i++) begin
            pop_cnt = pop_cnt + CNT_W'(smp_q[i]);
        end
        fine_full = CNT_W'(NPHASE) - pop_cnt;
        fine      = fine_full[FINE_W-1:0];
        hit       = (state_q == ARMED) && en && (smp_q != '0);
    end

    // Next-state logic: a hit starts dead time, then the line must go low before re-arming
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (phase_smp == '0) begin
                        state_d = ARMED;
                    end else begin
                        state_d = WAIT_LOW;
                    end
                end
                ARMED: begin
                    if (hit) begin
                        state_d = DEAD;
                        dcnt_d  = DCNT_W'(DEAD_CYC - 1);
                    end
                end
                DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = WAIT_LOW;
                    end else begin
                        dcnt_d = dcnt_q - DCNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (smp_q == '0) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 2 holds the assembled timestamp and the write request for one cycle
    always_comb begin
        s2_ts_d  = {crs_q, fine};
        wr_req_d = hit;
    end

    // FIFO bookkeeping; the head register is reloaded from the post-update memory image
    always_comb begin
        pop     = ts_ready && ts_valid_q;
        push_ok = wr_req_q && ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
        drop    = wr_req_q && !push_ok;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = s2_ts_q;
        end

        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end

        ts_valid_d = (level_d != '0);
        ts_data_d  = '0;
        if (ts_valid_d) begin
            ts_data_d = mem_d[rd_ptr_d];
        end

        ovf_d = ovf_q;
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Control and pipeline registers, all cleared by reset so in-flight hits are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_q   <= '0;
            smp_q      <= '0;
            crs_q      <= '0;
            state_q    <= IDLE;
            dcnt_q     <= '0;
            s2_ts_q    <= '0;
            wr_req_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ts_data_q  <= '0;
            ts_valid_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            coarse_q   <= coarse_d;
            smp_q      <= smp_d;
            crs_q      <= crs_d;
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            s2_ts_q    <= s2_ts_d;
            wr_req_q   <= wr_req_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ts_data_q  <= ts_data_d;
            ts_valid_q <= ts_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage needs no reset: the pointers and level decide what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ts_data      = ts_data_q;
    assign ts_valid     = ts_valid_q;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;
    assign armed        = (state_q == ARMED);

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// tb_tdc_hit_encoder
// Directed bench for the TDC hit encoder. A second instance with an 8-bit
// coarse counter is driven with the same inputs, so coarse wrap-around can be
// seen without running 2^24 cycles.
module tb_tdc_hit_encoder;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic [11:0] smp_i;
    logic        ready_i;

    logic [27:0] ts_data;
    logic        ts_valid;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic        armed;

    logic [11:0] w_ts_data;
    logic        w_ts_valid;
    logic [4:0]  w_level;
    logic [15:0] w_ovf;
    logic        w_armed;

    int          checks;
    int          errors;

    // independent model of the coarse counter
    logic [23:0] m_coarse;
    // expected FIFO contents, oldest first
    logic [27:0] exp_q [$];

    typedef struct {
        logic [11:0] smp;
        logic [3:0]  fine;
    } vec_t;

    vec_t vecs [8];

    tdc_hit_encoder u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en_i),
        .phase_smp    (smp_i),
        .ts_data      (ts_data),
        .ts_valid     (ts_valid),
        .ts_ready     (ready_i),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .armed        (armed)
    );

    tdc_hit_encoder #(.COARSE_W(8)) u_wrap (
        .clk          (clk),
        .rst          (rst),
        .en           (en_i),
        .phase_smp    (smp_i),
        .ts_data      (w_ts_data),
        .ts_valid     (w_ts_valid),
        .ts_ready     (ready_i),
        .fifo_level   (w_level),
        .overflow_cnt (w_ovf),
        .armed        (w_armed)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference coarse counter
    always @(posedge clk) begin
        if (rst) m_coarse <= '0;
        else if (en_i) m_coarse <= m_coarse + 24'd1;
    end

    // hard stop in case a sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic en, input logic [11:0] smp, input logic ready);
        en_i    = en;
        smp_i   = smp;
        ready_i = ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // single hit on an empty, armed FIFO: checks latency, data, pop and re-arm
    task automatic doHit(input logic [11:0] smp, input logic [3:0] fine);
        logic [27:0] e;
        logic [11:0] ew;
        e  = {m_coarse, fine};
        ew = {m_coarse[7:0], fine};
        applyStimulus(1'b1, smp, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        checkOutput("lat_not_early", ts_valid, 0);
        @(negedge clk);
        checkOutput("lat_valid", ts_valid, 1);
        checkOutput("ts_data", ts_data, e);
        checkOutput("level_one", fifo_level, 1);
        checkOutput("wrap_ts_data", w_ts_data, ew);
        checkOutput("wrap_level", w_level, 1);
        applyStimulus(1'b1, 12'h000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        checkOutput("pop_empty", ts_valid, 0);
        repeat (4) @(negedge clk);
        checkOutput("rearmed", armed, 1);
    endtask

    // one pulse followed by enough low cycles for the next hit to be captured
    task automatic hitPulse(input logic [11:0] smp, input logic [3:0] fine, input bit accept);
        if (accept) exp_q.push_back({m_coarse, fine});
        applyStimulus(1'b1, smp, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    // pop n entries back to back, comparing against the expected queue
    task automatic drainCheck(input int n);
        logic [27:0] e;
        applyStimulus(1'b1, 12'h000, 1'b1);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checkOutput("drain_valid", ts_valid, 1);
            checkOutput("drain_order", ts_data, e);
            @(negedge clk);
        end
        applyStimulus(1'b1, 12'h000, 1'b0);
        checkOutput("drain_empty", fifo_level, 0);
    endtask

    initial begin
        logic [27:0] e;
        logic [11:0] s;
        int          d;

        checks = 0;
        errors = 0;

        vecs[0] = '{smp: 12'h03F, fine: 4'd6};
        vecs[1] = '{smp: 12'h0FB, fine: 4'd5};
        vecs[2] = '{smp: 12'hFFF, fine: 4'd0};
        vecs[3] = '{smp: 12'h001, fine: 4'd11};
        vecs[4] = '{smp: 12'h800, fine: 4'd11};
        vecs[5] = '{smp: 12'h7FF, fine: 4'd1};
        vecs[6] = '{smp: 12'hAAA, fine: 4'd6};
        vecs[7] = '{smp: 12'hF0F, fine: 4'd4};

        // reset state
        rst = 1'b1;
        applyStimulus(1'b0, 12'h000, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", ts_valid, 0);
        checkOutput("rst_data", ts_data, 0);
        checkOutput("rst_level", fifo_level, 0);
        checkOutput("rst_ovf", overflow_cnt, 0);
        checkOutput("rst_armed", armed, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        checkOutput("armed_after_idle", armed, 1);

        // first hit at coarse 100
        repeat (100 - int'(m_coarse)) @(negedge clk);
        doHit(12'h03F, 4'd6);

        // fine code table
        for (int i = 0; i < 8; i++) begin
            doHit(vecs[i].smp, vecs[i].fine);
        end

        // second pulse inside dead time is ignored
        e = {m_coarse, 4'd6};
        applyStimulus(1'b1, 12'h03F, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h03F, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("dead_one_entry", fifo_level, 1);
        checkOutput("dead_data", ts_data, e);
        applyStimulus(1'b1, 12'h000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        checkOutput("dead_pop", fifo_level, 0);

        // line held high for 10 cycles gives one entry, re-arm only after it drops
        e = {m_coarse, 4'd10};
        applyStimulus(1'b1, 12'h0C0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("held_not_armed", armed, 0);
        checkOutput("held_one_entry", fifo_level, 1);
        checkOutput("held_data", ts_data, e);
        applyStimulus(1'b1, 12'h000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("held_rearmed", armed, 1);
        applyStimulus(1'b1, 12'h000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        checkOutput("held_pop", fifo_level, 0);
        doHit(12'h00F, 4'd8);

        // 20 hits with no readout: 16 stored, 4 dropped
        for (int k = 0; k < 20; k++) begin
            s = 12'hFFF;
            s = s >> (k % 12);
            hitPulse(s, 4'(k % 12), k < 16);
        end
        checkOutput("ovf_level", fifo_level, 16);
        checkOutput("ovf_count", overflow_cnt, 4);
        checkOutput("ovf_valid", ts_valid, 1);
        drainCheck(16);

        // full FIFO with push and pop in the same cycle
        for (int k = 0; k < 16; k++) begin
            s = 12'hFFF;
            s = s >> ((k + 5) % 12);
            hitPulse(s, 4'((k + 5) % 12), 1'b1);
        end
        e = {m_coarse, 4'd9};
        applyStimulus(1'b1, 12'h007, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        checkOutput("full_level_before", fifo_level, 16);
        checkOutput("full_head_before", ts_data, exp_q[0]);
        applyStimulus(1'b1, 12'h000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(e);
        checkOutput("full_level_same", fifo_level, 16);
        checkOutput("full_ovf_same", overflow_cnt, 4);
        checkOutput("wrap_ovf_same", w_ovf, 4);
        repeat (3) @(negedge clk);
        drainCheck(16);

        // en=0 during dead time returns to IDLE but keeps the captured entry
        e = {m_coarse, 4'd4};
        applyStimulus(1'b1, 12'h0FF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 12'h000, 1'b0);
        @(negedge clk);
        checkOutput("en0_not_armed", armed, 0);
        checkOutput("en0_valid", ts_valid, 1);
        checkOutput("en0_level", fifo_level, 1);
        checkOutput("en0_data", ts_data, e);
        repeat (3) @(negedge clk);
        checkOutput("en0_fifo_intact", fifo_level, 1);
        checkOutput("en0_data_stable", ts_data, e);
        applyStimulus(1'b1, 12'h000, 1'b0);
        @(negedge clk);
        checkOutput("en1_rearmed", armed, 1);
        applyStimulus(1'b1, 12'h000, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        checkOutput("en0_pop", ts_valid, 0);

        // coarse wrap on the 8-bit instance: hits at low byte 250 and 258 -> 2
        d = (250 - int'(m_coarse[7:0]) + 256) % 256;
        repeat (d) @(negedge clk);
        doHit(12'h03F, 4'd6);
        doHit(12'h0FB, 4'd5);

        // reset while an entry is visible clears everything
        applyStimulus(1'b1, 12'h03F, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 12'h000, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("prerst_valid", ts_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", ts_valid, 0);
        checkOutput("midrst_data", ts_data, 0);
        checkOutput("midrst_level", fifo_level, 0);
        checkOutput("midrst_ovf", overflow_cnt, 0);
        checkOutput("midrst_armed", armed, 0);
        checkOutput("midrst_wrap_valid", w_ts_valid, 0);
        checkOutput("midrst_wrap_armed", w_armed, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_armed", armed, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
